// File: rtl/sevenseg_mux_driver_pkg.sv
// ----------------------------------------------------------------------------
// sevenseg_mux_driver_pkg
// Shared definitions for the multiplexed 7-segment driver:
//   - SEG_BLANK and the 16 hex glyphs (active-low, bit 6 = g ... bit 0 = a)
//   - scan phase enum (dead time vs. lit part of a digit slot)
//   - clog2 helper for sizing the slot and index counters (minimum 1 bit)
// ----------------------------------------------------------------------------
package sevenseg_mux_driver_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_HEX_0 = 7'b1000000;
  localparam seg_t SEG_HEX_1 = 7'b1111001;
  localparam seg_t SEG_HEX_2 = 7'b0100100;
  localparam seg_t SEG_HEX_3 = 7'b0110000;
  localparam seg_t SEG_HEX_4 = 7'b0011001;
  localparam seg_t SEG_HEX_5 = 7'b0010010;
  localparam seg_t SEG_HEX_6 = 7'b0000010;
  localparam seg_t SEG_HEX_7 = 7'b1111000;
  localparam seg_t SEG_HEX_8 = 7'b0000000;
  localparam seg_t SEG_HEX_9 = 7'b0010000;
  localparam seg_t SEG_HEX_A = 7'b0001000;
  localparam seg_t SEG_HEX_B = 7'b0000011;
  localparam seg_t SEG_HEX_C = 7'b1000110;
  localparam seg_t SEG_HEX_D = 7'b0100001;
  localparam seg_t SEG_HEX_E = 7'b0000110;
  localparam seg_t SEG_HEX_F = 7'b0001110;

  // Phase within a digit slot: anodes are all off during PH_DEAD so the
  // previous digit's segments never bleed onto the next anode.
  typedef enum logic {
    PH_DEAD = 1'b0,
    PH_LIT  = 1'b1
  } phase_e;

  // Bits needed to hold 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/sevenseg_mux_driver_hex_seg_lut.sv
// ----------------------------------------------------------------------------
// hex_seg_lut
// Purely combinational hex-to-7-segment decode, active-low outputs.
// Ports:
//   i_hex  in  4  hex digit to decode
//   o_seg  out 7  segment pattern, bit 6 = g ... bit 0 = a, 0 = segment on
// ----------------------------------------------------------------------------
module hex_seg_lut
  import sevenseg_mux_driver_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_hex)
      4'h0:    o_seg = SEG_HEX_0;
      4'h1:    o_seg = SEG_HEX_1;
      4'h2:    o_seg = SEG_HEX_2;
      4'h3:    o_seg = SEG_HEX_3;
      4'h4:    o_seg = SEG_HEX_4;
      4'h5:    o_seg = SEG_HEX_5;
      4'h6:    o_seg = SEG_HEX_6;
      4'h7:    o_seg = SEG_HEX_7;
      4'h8:    o_seg = SEG_HEX_8;
      4'h9:    o_seg = SEG_HEX_9;
      4'hA:    o_seg = SEG_HEX_A;
      4'hB:    o_seg = SEG_HEX_B;
      4'hC:    o_seg = SEG_HEX_C;
      4'hD:    o_seg = SEG_HEX_D;
      4'hE:    o_seg = SEG_HEX_E;
      default: o_seg = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/sevenseg_mux_driver.sv
// ----------------------------------------------------------------------------
// sevenseg_mux_driver
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Each digit owns a slot of REFRESH_DIV clocks; the first DEAD_CYCLES clocks
// of every slot keep all anodes off. New data is staged in a pending buffer
// and copied into the displayed (shadow) buffer only at the frame boundary.
// Ports:
//   clk         in   1            system clock
//   rst_n       in   1            asynchronous active-low reset
//   value       in   4*N_DIGITS   hex digits, digit i = value[4i+3:4i]
//   dp_in       in   N_DIGITS     decimal point request per digit (1 = on)
//   digit_en    in   N_DIGITS     1 = digit may light, 0 = forced blank
//   blank_lz    in   1            runtime leading-zero blank select
//   load        in   1            capture value/dp_in/digit_en
//   seg         out  7            active-low segments (bit 6 = g)
//   dp          out  1            active-low decimal point
//   an          out  N_DIGITS     active-low anode enables
//   frame_done  out  1            one-cycle pulse at the end of each scan
// All outputs are registered: they reflect slot/index state one clock late.
// ----------------------------------------------------------------------------
module sevenseg_mux_driver
  import sevenseg_mux_driver_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2,
  parameter int LZ_BLANK_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic                    blank_lz,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_done
);

  localparam int SLOT_W = clog2(REFRESH_DIV);
  localparam int IDX_W  = clog2(N_DIGITS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam bit LZ_EN = (LZ_BLANK_EN != 0);

  // Scan state
  logic [SLOT_W-1:0]     r_slot;
  logic [IDX_W-1:0]      r_index;

  // Pending (staged) and shadow (displayed) buffers
  logic [4*N_DIGITS-1:0] r_pend_value;
  logic [N_DIGITS-1:0]   r_pend_dp;
  logic [N_DIGITS-1:0]   r_pend_en;
  logic                  r_pend_valid;
  logic [4*N_DIGITS-1:0] r_shd_value;
  logic [N_DIGITS-1:0]   r_shd_dp;
  logic [N_DIGITS-1:0]   r_shd_en;

  // Output registers
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [N_DIGITS-1:0]   r_an;
  logic                  r_frame_done;

  logic                  w_slot_wrap;
  logic                  w_boundary;
  logic                  w_in_dead;
  phase_e                w_phase;
  logic                  w_lz_active;
  logic [N_DIGITS-1:0]   w_lz_blank;
  logic [3:0]            w_digit [N_DIGITS];
  logic [N_DIGITS-1:0]   w_digit_zero;
  logic [N_DIGITS-1:0]   w_an_sel;
  logic [3:0]            w_cur_digit;
  logic [6:0]            w_cur_seg;
  logic                  w_cur_lit;
  logic                  w_cur_dp;

  assign w_slot_wrap = (r_slot == SLOT_LAST);
  assign w_boundary  = w_slot_wrap && (r_index == IDX_LAST);
  assign w_lz_active = LZ_EN && blank_lz;

  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign w_in_dead = 1'b0;
    end else begin : g_dead
      assign w_in_dead = (r_slot < SLOT_W'(DEAD_CYCLES));
    end
  endgenerate

  assign w_phase = w_in_dead ? PH_DEAD : PH_LIT;

  // Per-digit slices of the shadow value and the one-hot (active-low) anode
  // pattern for the currently indexed digit.
  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign w_digit[gi]      = r_shd_value[4*gi +: 4];
      assign w_digit_zero[gi] = (r_shd_value[4*gi +: 4] == 4'h0);
      assign w_an_sel[gi]     = (r_index != IDX_W'(gi));
    end
  endgenerate

  // Leading-zero blanking: walk from the most significant digit down. The run
  // continues only through zero digits without a decimal point; digit 0 is
  // always shown. Enable state does not break the run, only value/dp do.
  always_comb begin : p_lz
    logic v_run;
    w_lz_blank = '0;
    v_run      = w_lz_active;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      v_run         = v_run && w_digit_zero[i] && !r_shd_dp[i];
      w_lz_blank[i] = v_run;
    end
  end

  assign w_cur_digit = w_digit[r_index];
  assign w_cur_lit   = r_shd_en[r_index] && !w_lz_blank[r_index];
  assign w_cur_dp    = r_shd_dp[r_index];

  hex_seg_lut u_hex_seg_lut (
    .i_hex (w_cur_digit),
    .o_seg (w_cur_seg)
  );

  // Slot / digit counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot  <= '0;
      r_index <= '0;
    end else begin
      if (w_slot_wrap) begin
        r_slot  <= '0;
        r_index <= (r_index == IDX_LAST) ? '0 : r_index + IDX_W'(1);
      end else begin
        r_slot  <= r_slot + SLOT_W'(1);
      end
    end
  end

  // Double buffer. A load landing on the boundary edge bypasses the pending
  // stage so it is displayed in the very next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_value <= '0;
      r_pend_dp    <= '0;
      r_pend_en    <= '1;
      r_pend_valid <= 1'b0;
      r_shd_value  <= '0;
      r_shd_dp     <= '0;
      r_shd_en     <= '1;
    end else if (w_boundary) begin
      r_pend_valid <= 1'b0;
      if (load) begin
        r_shd_value <= value;
        r_shd_dp    <= dp_in;
        r_shd_en    <= digit_en;
      end else if (r_pend_valid) begin
        r_shd_value <= r_pend_value;
        r_shd_dp    <= r_pend_dp;
        r_shd_en    <= r_pend_en;
      end
    end else if (load) begin
      r_pend_value <= value;
      r_pend_dp    <= dp_in;
      r_pend_en    <= digit_en;
      r_pend_valid <= 1'b1;
    end
  end

  // Registered scan outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an         <= '1;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      if (w_phase == PH_DEAD) begin
        r_an  <= '1;
        r_seg <= SEG_BLANK;
        r_dp  <= 1'b1;
      end else begin
        // A blanked digit keeps its anode driven so the scan timing is uniform.
        r_an  <= w_an_sel;
        r_seg <= w_cur_lit ? w_cur_seg : SEG_BLANK;
        r_dp  <= w_cur_lit ? ~w_cur_dp : 1'b1;
      end
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule
